// File: rtl/sine_sweep_ctrl_if.sv
// Control/config and sample-side signals of the sine sweep sequencer.
// master: config/control logic driving the sequencer.
// slave: the sequencer itself.
interface sine_sweep_ctrl_if #(
    parameter int unsigned PHASE_W = 16,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DWELL_W = 16
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [PHASE_W-1:0] cfg_inc_start;
    logic [PHASE_W-1:0] cfg_inc_stop;
    logic [PHASE_W-1:0] cfg_inc_step;
    logic [DWELL_W-1:0] cfg_dwell;
    logic               start;
    logic               stop;
    logic               sample_tick;
    logic [ADDR_W-1:0]  rom_addr;
    logic [PHASE_W-1:0] phase_inc;
    logic               busy;
    logic               done;

    modport master (
        output cfg_valid, cfg_inc_start, cfg_inc_stop, cfg_inc_step, cfg_dwell, start, stop,
        input  cfg_ready, sample_tick, rom_addr, phase_inc, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_inc_start, cfg_inc_stop, cfg_inc_step, cfg_dwell, start, stop,
        output cfg_ready, sample_tick, rom_addr, phase_inc, busy, done
    );
endinterface

// File: rtl/sine_sweep_ctrl.sv
// Sine sweep sequencer: phase accumulator driving the sine ROM address, sample
// strobe every TICK_DIV cycles, and a linear sweep of the phase increment.
// Optional feature macro: SINE_SWEEP_LOOP_EN (sweep restarts from the start
// increment with continuous phase instead of ending).
module sine_sweep_ctrl #(
    parameter int unsigned PHASE_W  = 16,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned TICK_DIV = 100,
    parameter int unsigned DWELL_W  = 16
) (
    input logic              clk_100,
    input logic              rst,
    sine_sweep_ctrl_if.slave bus
);
    localparam int unsigned TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q;
    logic [PHASE_W-1:0] inc_start_q, inc_stop_q, inc_step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               cfg_loaded_q;
    logic [PHASE_W-1:0] phase_acc_q, phase_inc_q;
    logic [TICK_W-1:0]  tick_cnt_q;
    logic [DWELL_W-1:0] dwell_cnt_q;
    logic               sample_tick_q, done_q;

    logic               cfg_accept, loaded, tick_now, dwell_end, sweep_end;
    logic [PHASE_W-1:0] start_inc;
    logic [DWELL_W-1:0] dwell_eff;
    logic [PHASE_W:0]   inc_next;

    // An offer accepted in the same cycle as start feeds this sweep directly.
    assign cfg_accept = bus.cfg_valid && (state_q == StIdle);
    assign loaded     = cfg_loaded_q || cfg_accept;
    assign start_inc  = cfg_accept ? bus.cfg_inc_start : inc_start_q;
    assign tick_now   = (state_q == StRun) && (tick_cnt_q == TICK_LAST);
    assign dwell_eff  = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
    assign dwell_end  = ((dwell_cnt_q + DWELL_W'(1)) == dwell_eff);
    // One extra bit so an overflowing sum always counts as past the stop value.
    assign inc_next   = {1'b0, phase_inc_q} + {1'b0, inc_step_q};
    assign sweep_end  = tick_now && dwell_end && (inc_next > {1'b0, inc_stop_q});

    assign bus.cfg_ready   = (state_q == StIdle);
    assign bus.busy        = (state_q == StRun);
    assign bus.sample_tick = sample_tick_q;
    assign bus.done        = done_q;
    assign bus.rom_addr    = phase_acc_q[PHASE_W-1 -: ADDR_W];
    assign bus.phase_inc   = phase_inc_q;

    // Sweep FSM together with config capture, counters and registered strobes.
    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            inc_start_q   <= '0;
            inc_stop_q    <= '0;
            inc_step_q    <= '0;
            dwell_q       <= '0;
            cfg_loaded_q  <= 1'b0;
            phase_acc_q   <= '0;
            phase_inc_q   <= '0;
            tick_cnt_q    <= '0;
            dwell_cnt_q   <= '0;
            sample_tick_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            sample_tick_q <= 1'b0;
            done_q        <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cfg_accept) begin
                        inc_start_q  <= bus.cfg_inc_start;
                        inc_stop_q   <= bus.cfg_inc_stop;
                        inc_step_q   <= bus.cfg_inc_step;
                        dwell_q      <= bus.cfg_dwell;
                        cfg_loaded_q <= 1'b1;
                    end
                    if (bus.start && loaded && !bus.stop) begin
                        state_q     <= StRun;
                        phase_acc_q <= '0;
                        tick_cnt_q  <= '0;
                        dwell_cnt_q <= '0;
                        phase_inc_q <= start_inc;
                    end
                end
                StRun: begin
                    if (bus.stop) begin
                        state_q     <= StIdle;
                        phase_acc_q <= '0;
                        phase_inc_q <= '0;
                        tick_cnt_q  <= '0;
                        dwell_cnt_q <= '0;
                    end else begin
                        tick_cnt_q <= tick_now ? '0 : tick_cnt_q + TICK_W'(1);
                        if (tick_now) begin
                            sample_tick_q <= 1'b1;
                            phase_acc_q   <= phase_acc_q + phase_inc_q;
                            if (dwell_end) begin
                                dwell_cnt_q <= '0;
                                if (sweep_end) begin
                                    done_q <= 1'b1;
`ifdef SINE_SWEEP_LOOP_EN
                                    phase_inc_q <= inc_start_q;
`else
                                    state_q <= StDone;
`endif
                                end else begin
                                    phase_inc_q <= inc_next[PHASE_W-1:0];
                                end
                            end else begin
                                dwell_cnt_q <= dwell_cnt_q + DWELL_W'(1);
                            end
                        end
                    end
                end
                StDone: begin
                    state_q     <= StIdle;
                    phase_acc_q <= '0;
                    phase_inc_q <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
